// File: rtl/mult_fu_pipe_if.sv
// Issue, CDB and flush signals between the RS/CDB side (master) and the
// multiplier functional unit (slave).
interface mult_fu_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 7
);
    logic             issue_valid;
    logic [XLEN-1:0]  issue_opa;
    logic [XLEN-1:0]  issue_opb;
    logic [TAG_W-1:0] issue_T;
    logic             squash;
    logic             cdb_grant;
    logic             mult_ready;
    logic             done_valid;
    logic [XLEN-1:0]  done_result;
    logic [TAG_W-1:0] done_T;

    modport master (
        output issue_valid, issue_opa, issue_opb, issue_T, squash, cdb_grant,
        input  mult_ready, done_valid, done_result, done_T
    );

    modport slave (
        input  issue_valid, issue_opa, issue_opb, issue_T, squash, cdb_grant,
        output mult_ready, done_valid, done_result, done_T
    );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined shift-and-add multiplier: each stage folds XLEN/NUM_STAGES
// multiplier bits into the running product. Whole pipe freezes on CDB stall.
module mult_fu_pipe #(
    parameter int XLEN       = 64,
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 7
) (
    input logic          clock,
    input logic          reset,
    mult_fu_pipe_if.slave bus
);
    localparam int CHUNK = XLEN / NUM_STAGES;
    localparam logic [XLEN-1:0] CHUNK_MASK = XLEN'({CHUNK{1'b1}});

    logic [NUM_STAGES-1:0] vld_q;
    logic [TAG_W-1:0]      tag_q    [NUM_STAGES];
    logic [XLEN-1:0]       prod_q   [NUM_STAGES];
    logic [XLEN-1:0]       mcand_q  [NUM_STAGES];
    logic [XLEN-1:0]       mplier_q [NUM_STAGES];

    logic [TAG_W-1:0]      tag_d    [NUM_STAGES];
    logic [XLEN-1:0]       prod_d   [NUM_STAGES];
    logic [XLEN-1:0]       mcand_d  [NUM_STAGES];
    logic [XLEN-1:0]       mplier_d [NUM_STAGES];

    logic            stall;
    logic            accept;
    logic [XLEN-1:0] in_mcand;
    logic [XLEN-1:0] in_mplier;

    assign stall  = vld_q[NUM_STAGES-1] & ~bus.cdb_grant;
    assign accept = bus.issue_valid & ~stall & ~bus.squash;

    // Bubbles carry zero operands so done_result never sees undriven inputs.
    assign in_mcand  = accept ? bus.issue_opa : '0;
    assign in_mplier = accept ? bus.issue_opb : '0;

    always_comb begin
        tag_d[0]    = accept ? bus.issue_T : '0;
        prod_d[0]   = in_mcand * (in_mplier & CHUNK_MASK);
        mcand_d[0]  = in_mcand << CHUNK;
        mplier_d[0] = in_mplier >> CHUNK;
        for (int k = 1; k < NUM_STAGES; k++) begin
            tag_d[k]    = tag_q[k-1];
            prod_d[k]   = prod_q[k-1] + mcand_q[k-1] * (mplier_q[k-1] & CHUNK_MASK);
            mcand_d[k]  = mcand_q[k-1] << CHUNK;
            mplier_d[k] = mplier_q[k-1] >> CHUNK;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                tag_q[k]    <= '0;
                prod_q[k]   <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
            end
        end else begin
            // Squash wins over stall: everything in flight is dropped.
            if (bus.squash) begin
                vld_q <= '0;
            end else if (!stall) begin
                vld_q <= (vld_q << 1) | NUM_STAGES'(accept);
            end
            if (!stall) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    tag_q[k]    <= tag_d[k];
                    prod_q[k]   <= prod_d[k];
                    mcand_q[k]  <= mcand_d[k];
                    mplier_q[k] <= mplier_d[k];
                end
            end
        end
    end

    assign bus.mult_ready  = ~stall;
    assign bus.done_valid  = vld_q[NUM_STAGES-1];
    assign bus.done_result = prod_q[NUM_STAGES-1];
    assign bus.done_T      = tag_q[NUM_STAGES-1];
endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed bench for mult_fu_pipe: reset, latency, bursts, wrap, stall,
// squash and asynchronous reset, with hand-computed products.
module tb_mult_fu_pipe;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mult_fu_pipe_if #(.XLEN(64), .TAG_W(7)) bus();

    mult_fu_pipe #(.XLEN(64), .NUM_STAGES(4), .TAG_W(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic [63:0] vr [8];
    logic [6:0]  vt [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_issue(input logic v, input logic [63:0] a, input logic [63:0] b,
                             input logic [6:0] t);
        bus.issue_valid = v;
        bus.issue_opa   = a;
        bus.issue_opb   = b;
        bus.issue_T     = t;
    endtask

    task automatic load_vec(input int i, input logic [63:0] a, input logic [63:0] b,
                            input logic [6:0] t, input logic [63:0] r);
        va[i] = a;
        vb[i] = b;
        vt[i] = t;
        vr[i] = r;
    endtask

    // Issue n back-to-back ops from negedge 0; op i must be visible at negedge i+4.
    task automatic run_burst(input int n);
        for (int c = 0; c <= n + 4; c++) begin
            if (c >= 4 && c - 4 < n) begin
                chk("burst_valid",  64'(bus.done_valid), 64'd1);
                chk("burst_result", bus.done_result, vr[c-4]);
                chk("burst_tag",    64'(bus.done_T), 64'(vt[c-4]));
            end else begin
                chk("burst_idle", 64'(bus.done_valid), 64'd0);
            end
            if (c < n) set_issue(1'b1, va[c], vb[c], vt[c]);
            else       set_issue(1'b0, 64'd0, 64'd0, 7'd0);
            @(negedge clock);
        end
    endtask

    initial begin
        bus.squash    = 1'b0;
        bus.cdb_grant = 1'b1;
        set_issue(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 7'(($urandom)));

        // Held in reset with an issue pending
        repeat (3) begin
            @(negedge clock);
            chk("rst_valid",  64'(bus.done_valid), 64'd0);
            chk("rst_ready",  64'(bus.mult_ready), 64'd1);
            chk("rst_result", bus.done_result, 64'd0);
            chk("rst_tag",    64'(bus.done_T), 64'd0);
        end
        reset = 1'b1;
        set_issue(1'b0, 64'd0, 64'd0, 7'd0);
        repeat (6) begin
            @(negedge clock);
            chk("post_rst_idle", 64'(bus.done_valid), 64'd0);
        end

        // Single op
        load_vec(0, 64'd3, 64'd5, 7'd3, 64'd15);
        run_burst(1);

        // Back-to-back
        load_vec(0, 64'd2,  64'd7,  7'd4, 64'd14);
        load_vec(1, 64'd10, 64'd10, 7'd5, 64'd100);
        load_vec(2, 64'd0,  64'd99, 7'd6, 64'd0);
        load_vec(3, 64'd1,  64'h1234, 7'd7, 64'h1234);
        run_burst(4);

        // Wrap-around, signed and upper multiplier chunks
        load_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 7'd8, 64'hFFFF_FFFF_FFFF_FFFE);
        load_vec(1, 64'h1_0000_0000, 64'h1_0000_0000, 7'd9, 64'd0);
        load_vec(2, 64'h8000_0000_0000_0000, 64'd3, 7'd10, 64'h8000_0000_0000_0000);
        load_vec(3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 7'd11, 64'hFFFF_FFFF_FFFF_FFF1);
        load_vec(4, 64'd3, 64'h0001_0001_0001_0001, 7'd12, 64'h0003_0003_0003_0003);
        load_vec(5, 64'h0123_4567_89AB_CDEF, 64'h10, 7'd13, 64'h1234_5678_9ABC_DEF0);
        load_vec(6, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 7'd14, 64'hFFFF_FFFE_0000_0001);
        run_burst(7);

        // Stall with three ops in flight
        set_issue(1'b1, 64'd6, 64'd7, 7'd20);
        @(negedge clock);
        set_issue(1'b1, 64'd11, 64'd11, 7'd21);
        @(negedge clock);
        set_issue(1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 7'd22);
        @(negedge clock);
        chk("stall_pre_idle", 64'(bus.done_valid), 64'd0);
        set_issue(1'b0, 64'd0, 64'd0, 7'd0);
        bus.cdb_grant = 1'b0;
        @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            chk("stall_valid",  64'(bus.done_valid), 64'd1);
            chk("stall_result", bus.done_result, 64'd42);
            chk("stall_tag",    64'(bus.done_T), 64'd20);
            chk("stall_ready",  64'(bus.mult_ready), 64'd0);
            if (s < 3) begin
                set_issue(1'b1, 64'd5, 64'd5, 7'd23);
                @(negedge clock);
            end
        end
        bus.cdb_grant = 1'b1;
        set_issue(1'b0, 64'd0, 64'd0, 7'd0);
        @(negedge clock);
        chk("drain1_valid",  64'(bus.done_valid), 64'd1);
        chk("drain1_result", bus.done_result, 64'd121);
        chk("drain1_tag",    64'(bus.done_T), 64'd21);
        @(negedge clock);
        chk("drain2_valid",  64'(bus.done_valid), 64'd1);
        chk("drain2_result", bus.done_result, 64'hFFFF_FFFE_0000_0001);
        chk("drain2_tag",    64'(bus.done_T), 64'd22);
        repeat (4) begin
            @(negedge clock);
            chk("drain_idle", 64'(bus.done_valid), 64'd0);
        end

        // Squash with three ops in flight plus a concurrent issue
        set_issue(1'b1, 64'd2, 64'd2, 7'd30);
        @(negedge clock);
        set_issue(1'b1, 64'd3, 64'd3, 7'd31);
        @(negedge clock);
        set_issue(1'b1, 64'd4, 64'd4, 7'd32);
        @(negedge clock);
        set_issue(1'b1, 64'd5, 64'd5, 7'd33);
        bus.squash = 1'b1;
        @(negedge clock);
        bus.squash = 1'b0;
        set_issue(1'b0, 64'd0, 64'd0, 7'd0);
        chk("squash_ready", 64'(bus.mult_ready), 64'd1);
        repeat (6) begin
            chk("squash_idle", 64'(bus.done_valid), 64'd0);
            @(negedge clock);
        end

        // Asynchronous reset while a result is parked at the output
        set_issue(1'b1, 64'd9, 64'd9, 7'd40);
        @(negedge clock);
        set_issue(1'b0, 64'd0, 64'd0, 7'd0);
        bus.cdb_grant = 1'b0;
        repeat (3) @(negedge clock);
        chk("ar_valid",  64'(bus.done_valid), 64'd1);
        chk("ar_result", bus.done_result, 64'd81);
        chk("ar_tag",    64'(bus.done_T), 64'd40);
        @(negedge clock);
        chk("ar_hold", 64'(bus.done_valid), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("ar_drop_valid",  64'(bus.done_valid), 64'd0);
        chk("ar_drop_result", bus.done_result, 64'd0);
        chk("ar_drop_tag",    64'(bus.done_T), 64'd0);
        chk("ar_drop_ready",  64'(bus.mult_ready), 64'd1);
        #1 reset = 1'b1;
        bus.cdb_grant = 1'b1;
        repeat (6) begin
            @(negedge clock);
            chk("ar_idle", 64'(bus.done_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
